// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD nibble width and a digit-count helper.
package bcd_pkg;

  localparam int BCD_NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Digits needed to show every unsigned bin_w-bit value: ceil(bin_w * log10(2)).
  // log10(2) is approximated as 0.30103, which is exact enough for any practical width.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] din,
  output logic [BCD_NIBBLE_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional two's-complement input: the magnitude is converted and the sign reported.
// A sticky flag marks results whose magnitude does not fit in DIGITS digits;
// in that case bcd_out holds the magnitude modulo 10**DIGITS.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int SIGNED_EN = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIN_W-1:0]               bin_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic                           sign_out,
  output logic                           overflow
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  mag;
  logic [BCD_W-1:0]  bcd_adj;

  logic signed [BIN_W-1:0] bin_s;
  logic                    neg;
  logic [BIN_W-1:0]        mag_in;

  // Magnitude in BIN_W unsigned bits; the most-negative operand wraps to 2**(BIN_W-1).
  assign bin_s  = bin_in;
  assign neg    = (SIGNED_EN != 0) && bin_in[BIN_W-1];
  assign mag_in = neg ? $unsigned(-bin_s) : bin_in;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Per-digit add-3 correction applied to the accumulator before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_out[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .dout (bcd_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Control FSM plus shift register, BCD accumulator, sign and sticky overflow.
  // SHIFT runs BIN_W shifting cycles, then one closing cycle with cnt==0 before DONE,
  // so out_valid rises BIN_W+1 cycles after the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mag      <= '0;
      bcd_out  <= '0;
      sign_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mag      <= mag_in;
            sign_out <= neg;
            bcd_out  <= '0;
            overflow <= 1'b0;
            cnt      <= CNT_W'(BIN_W);
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            bcd_out  <= {bcd_adj[BCD_W-2:0], mag[BIN_W-1]};
            mag      <= {mag[BIN_W-2:0], 1'b0};
            overflow <= overflow | bcd_adj[BCD_W-1];
            cnt      <= cnt - 1'b1;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv: three instances (default, signed, two-digit)
// share one stimulus stream and are checked against hand values and a small model.
module tb_bcd_seq_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] bin_in;

  logic        rdy_def, vld_def, sgn_def, ovf_def;
  logic [11:0] bcd_def;
  logic        rdy_sgn, vld_sgn, sgn_sgn, ovf_sgn;
  logic [11:0] bcd_sgn;
  logic        rdy_d2, vld_d2, sgn_d2, ovf_d2;
  logic [7:0]  bcd_d2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_seq_conv u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_def), .bin_in(bin_in),
    .out_valid(vld_def), .out_ready(out_ready), .bcd_out(bcd_def),
    .sign_out(sgn_def), .overflow(ovf_def)
  );

  bcd_seq_conv #(.BIN_W(8), .DIGITS(3), .SIGNED_EN(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_sgn), .bin_in(bin_in),
    .out_valid(vld_sgn), .out_ready(out_ready), .bcd_out(bcd_sgn),
    .sign_out(sgn_sgn), .overflow(ovf_sgn)
  );

  bcd_seq_conv #(.BIN_W(8), .DIGITS(2), .SIGNED_EN(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d2), .bin_in(bin_in),
    .out_valid(vld_d2), .out_ready(out_ready), .bcd_out(bcd_d2),
    .sign_out(sgn_d2), .overflow(ovf_d2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_bcd(input int mag, input int digits);
    logic [31:0] r;
    int m;
    r = '0;
    m = mag;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  rdy_def, 1);
    chk({tag, "_out_valid"}, vld_def, 0);
    chk({tag, "_bcd"},       bcd_def, 0);
    chk({tag, "_sign"},      sgn_def, 0);
    chk({tag, "_ovf"},       ovf_def, 0);
    chk({tag, "_sgn_sign"},  sgn_sgn, 0);
    chk({tag, "_d2_ovf"},    ovf_d2,  0);
    chk({tag, "_d2_valid"},  vld_d2,  0);
  endtask

  // Present an operand just after a rising edge; the next edge is the accept edge.
  task automatic start(input logic [7:0] v);
    chk("accept_ready", rdy_def, 1);
    bin_in   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; 0 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (vld_def) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convert(input logic [7:0] v);
    int lat;
    start(v);
    wait_done(lat);
    chk("latency", lat, 9);
    chk("valid_sgn", vld_sgn, 1);
    chk("valid_d2",  vld_d2,  1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", vld_def, 0);
  endtask

  task automatic check_model(input int v);
    int smag;
    smag = (v >= 128) ? 256 - v : v;
    chk("sweep_def_bcd",  bcd_def, pack_bcd(v, 3));
    chk("sweep_def_ovf",  ovf_def, 0);
    chk("sweep_sgn_bcd",  bcd_sgn, pack_bcd(smag, 3));
    chk("sweep_sgn_sign", sgn_sgn, (v >= 128) ? 1 : 0);
    chk("sweep_d2_bcd",   bcd_d2,  pack_bcd(v % 100, 2));
    chk("sweep_d2_ovf",   ovf_d2,  (v >= 100) ? 1 : 0);
  endtask

  initial begin
    int lat;
    int seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 255 on all three instances
    convert(8'd255);
    chk("d255_bcd",      bcd_def, 12'h255);
    chk("d255_ovf",      ovf_def, 0);
    chk("d255_sign",     sgn_def, 0);
    chk("s255_sign",     sgn_sgn, 1);
    chk("s255_bcd",      bcd_sgn, 12'h001);
    chk("d2_255_ovf",    ovf_d2,  1);
    chk("d2_255_bcd",    bcd_d2,  8'h55);
    release_out();

    convert(8'd0);
    chk("d0_bcd", bcd_def, 12'h000);
    release_out();

    convert(8'd9);
    chk("d9_bcd", bcd_def, 12'h009);
    release_out();

    convert(8'h80);
    chk("s80_sign", sgn_sgn, 1);
    chk("s80_bcd",  bcd_sgn, 12'h128);
    chk("d80_bcd",  bcd_def, 12'h128);
    release_out();

    convert(8'd99);
    chk("d2_99_ovf", ovf_d2, 0);
    chk("d2_99_bcd", bcd_d2, 8'h99);
    release_out();

    for (int v = 0; v < 256; v++) begin
      convert(8'(v));
      check_model(v);
      release_out();
    end

    // Backpressure: result held, second operand waits
    convert(8'd123);
    bin_in   = 8'd7;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", vld_def, 1);
      chk("bp_ready", rdy_def, 0);
      chk("bp_bcd",   bcd_def, 12'h123);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", vld_def, 0);
    chk("bp_release_ready", rdy_def, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp_second_latency", lat, 9);
    chk("bp_second_bcd", bcd_def, 12'h007);
    release_out();

    // Reset in the middle of a conversion
    start(8'd200);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("midreset");
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (vld_def || vld_sgn || vld_d2) seen = 1;
    end
    chk("no_stale_result", seen, 0);

    convert(8'd42);
    chk("d42_bcd", bcd_def, 12'h042);
    chk("d42_ovf", ovf_def, 0);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
